// File: rtl/crc_tx_stream_if.sv
// Word-stream handshake bundle: valid/ready with a DW-bit data word and an end-of-frame flag.
// The master drives valid/data/last; the slave returns ready.
interface crc_tx_stream_if #(
   parameter int DW = 8
);
   logic          valid;
   logic          ready;
   logic [DW-1:0] data;
   logic          last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/crc_tx_stream.sv
// Streaming CRC transmitter: forwards each accepted frame word unchanged, then appends
// the frame CRC as CRC_BW/DW beats (MSB first) through one output register stage.
module crc_tx_stream #(
   parameter int                DW      = 8,
   parameter int                CRC_BW  = 8,
   parameter logic [CRC_BW-1:0] POLY    = 8'h07,
   parameter logic [CRC_BW-1:0] INIT    = '0,
   parameter logic [CRC_BW-1:0] XOR_OUT = '0
) (
   input  logic              clk,
   input  logic              rst,
   crc_tx_stream_if.slave    s,
   crc_tx_stream_if.master   m,
   output logic              busy
);
   localparam int NBEATS = CRC_BW / DW;
   localparam int CW     = $clog2(NBEATS + 1);

   typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

   state_t              state_q, state_d;
   logic [CRC_BW-1:0]   crc_q, crc_d;
   logic [CRC_BW-1:0]   crc_sh_q, crc_sh_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                m_valid_q, m_valid_d;
   logic [DW-1:0]       m_data_q, m_data_d;
   logic                m_last_q, m_last_d;
   logic                load_en;
   logic                s_ready_c;
   logic                s_fire;
   logic [CRC_BW-1:0]   crc_nx;

   // One word of MSB-first, non-reflected LFSR division, fully unrolled.
   function automatic logic [CRC_BW-1:0] crc_step(input logic [CRC_BW-1:0] c_in,
                                                  input logic [DW-1:0]     d);
      logic [CRC_BW-1:0] c;
      logic              fb;
      c = c_in;
      for (int i = DW - 1; i >= 0; i--) begin
         fb = c[CRC_BW-1] ^ d[i];
         c  = c << 1;
         if (fb) c = c ^ POLY;
      end
      return c;
   endfunction

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      crc_sh_d  = crc_sh_q;
      cnt_d     = cnt_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;

      load_en   = !m_valid_q || m.ready;
      s_ready_c = load_en && (state_q != CRC) && !rst;
      s_fire    = s.valid && s_ready_c;
      crc_nx    = crc_step(crc_q, s.data);

      // A handshaked beat with nothing new behind it empties the register.
      if (load_en) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      case (state_q)
         IDLE, DATA: begin
            if (s_fire) begin
               m_valid_d = 1'b1;
               m_data_d  = s.data;
               m_last_d  = 1'b0;
               if (s.last) begin
                  state_d  = CRC;
                  crc_sh_d = crc_nx ^ XOR_OUT;
                  cnt_d    = '0;
                  crc_d    = INIT;
               end else begin
                  state_d  = DATA;
                  crc_d    = crc_nx;
               end
            end
         end
         CRC: begin
            if (load_en) begin
               m_valid_d = 1'b1;
               m_data_d  = crc_sh_q[CRC_BW-1 -: DW];
               crc_sh_d  = crc_sh_q << DW;
               cnt_d     = cnt_q + CW'(1);
               m_last_d  = (cnt_q == CW'(NBEATS - 1));
               // Once the final beat is in the register the input side may reopen;
               // busy stays high through m_valid until that beat is taken.
               if (cnt_q == CW'(NBEATS - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         crc_q     <= INIT;
         crc_sh_q  <= '0;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         crc_sh_q  <= crc_sh_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
      end
   end

   assign s.ready = s_ready_c;
   assign m.valid = m_valid_q;
   assign m.data  = m_data_q;
   assign m.last  = m_last_q;
   assign busy    = (state_q != IDLE) || m_valid_q;
endmodule

// File: tb/tb_crc_tx_stream.sv
// Bench for crc_tx_stream: CRC-8 instance plus two CRC-16 (0x1021) instances, checked
// against a long-division CRC model and known check values.
module tb_crc_tx_stream;
   typedef logic [7:0] bq_t[$];

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   int   stall_cnt = 0;
   logic drv_done;
   int   nexp;
   logic a_busy, b_busy, c_busy;

   crc_tx_stream_if #(.DW(8)) a_s(), a_m(), b_s(), b_m(), c_s(), c_m();

   crc_tx_stream #(.DW(8), .CRC_BW(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00)) u_a (
      .clk(clk), .rst(rst), .s(a_s), .m(a_m), .busy(a_busy));
   crc_tx_stream #(.DW(8), .CRC_BW(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000)) u_b (
      .clk(clk), .rst(rst), .s(b_s), .m(b_m), .busy(b_busy));
   crc_tx_stream #(.DW(8), .CRC_BW(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)) u_c (
      .clk(clk), .rst(rst), .s(c_s), .m(c_m), .busy(c_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] qa_d[$], qb_d[$], qc_d[$];
   logic       qa_l[$], qb_l[$], qc_l[$];

   // Beats that will be taken at the next rising edge.
   always @(negedge clk) begin
      if (!rst && a_m.valid && a_m.ready) begin qa_d.push_back(a_m.data); qa_l.push_back(a_m.last); end
      if (!rst && b_m.valid && b_m.ready) begin qb_d.push_back(b_m.data); qb_l.push_back(b_m.last); end
      if (!rst && c_m.valid && c_m.ready) begin qc_d.push_back(c_m.data); qc_l.push_back(c_m.last); end
   end

   // Remainder of (msg * x^w + init * x^len) over (x^w + poly), by long division on a bit array.
   function automatic logic [15:0] ref_crc(input bq_t msg, input int w, input logic [15:0] poly,
                                           input logic [15:0] init, input logic [15:0] xo);
      bit          bits[];
      int          n;
      logic [15:0] r;
      n = msg.size() * 8;
      bits = new[n + w];
      for (int i = 0; i < n; i++) bits[i] = msg[i / 8][7 - (i % 8)];
      for (int j = 0; j < w; j++) bits[j] = bits[j] ^ init[w - 1 - j];
      for (int i = 0; i < n; i++) begin
         if (bits[i]) begin
            bits[i] = 1'b0;
            for (int j = 1; j <= w; j++) bits[i + j] = bits[i + j] ^ poly[w - j];
         end
      end
      r = '0;
      for (int k = 0; k < w; k++) r[w - 1 - k] = bits[n + k];
      return r ^ xo;
   endfunction

   task automatic send_a(input bq_t w, input int gap_pct);
      int t;
      for (int i = 0; i < w.size(); i++) begin
         while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            a_s.valid = 1'b0;
            @(posedge clk); #1;
         end
         a_s.valid = 1'b1; a_s.data = w[i]; a_s.last = (i == w.size() - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (a_s.ready) break;
            stall_cnt++; t++;
            if (t > 500) break;
         end
         @(posedge clk); #1;
         if (t > 500) begin
            n_vec++; n_err++;
            $display("FAIL send_a_timeout: word %0d not accepted, s_ready=%b want 1", i, a_s.ready);
            a_s.valid = 1'b0;
            return;
         end
      end
      a_s.valid = 1'b0; a_s.last = 1'b0;
   endtask

   task automatic send_bc(input bq_t w);
      int t;
      for (int i = 0; i < w.size(); i++) begin
         b_s.valid = 1'b1; b_s.data = w[i]; b_s.last = (i == w.size() - 1);
         c_s.valid = 1'b1; c_s.data = w[i]; c_s.last = (i == w.size() - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (b_s.ready && c_s.ready) break;
            t++;
            if (t > 500) break;
         end
         @(posedge clk); #1;
         if (t > 500) begin
            n_vec++; n_err++;
            $display("FAIL send_bc_timeout: word %0d, b_ready=%b c_ready=%b want 1", i, b_s.ready, c_s.ready);
            break;
         end
      end
      b_s.valid = 1'b0; b_s.last = 1'b0;
      c_s.valid = 1'b0; c_s.last = 1'b0;
   endtask

   task automatic wait_beats(input int na, input int nb);
      int t = 0;
      while ((qa_d.size() < na || qb_d.size() < nb || qc_d.size() < nb) && t < 2000) begin
         @(negedge clk); t++;
      end
      @(posedge clk); #1;
   endtask

   task automatic clear_queues();
      qa_d.delete(); qa_l.delete(); qb_d.delete(); qb_l.delete(); qc_d.delete(); qc_l.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_vec++; if (a_m.valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", a_m.valid); end
      n_vec++; if (a_m.data !== 8'h00) begin n_err++; $display("FAIL rst_m_data: got %h want 00", a_m.data); end
      n_vec++; if (a_m.last !== 1'b0) begin n_err++; $display("FAIL rst_m_last: got %b want 0", a_m.last); end
      n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", a_busy); end
      n_vec++; if (a_s.ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0", a_s.ready); end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_vec++; if (a_s.ready !== 1'b1) begin n_err++; $display("FAIL post_rst_s_ready: got %b want 1", a_s.ready); end
      n_vec++; if (b_s.ready !== 1'b1) begin n_err++; $display("FAIL post_rst_b_s_ready: got %b want 1", b_s.ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_word();
      bq_t f, ed; logic el[$];
      f = {8'h01}; ed = {8'h01, 8'h07}; el = {1'b0, 1'b1};
      clear_queues(); a_m.ready = 1'b1;
      send_a(f, 0); wait_beats(2, 0);
      n_vec++; if (qa_d.size() !== 2) begin n_err++; $display("FAIL single_count: got %0d want 2", qa_d.size()); end
      for (int i = 0; i < ed.size() && i < qa_d.size(); i++) begin
         n_vec++;
         if (qa_d[i] !== ed[i] || qa_l[i] !== el[i]) begin
            n_err++; $display("FAIL single_beat%0d: got %h/%b want %h/%b", i, qa_d[i], qa_l[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_check_string();
      bq_t f, ed; logic el[$];
      f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      ed = f; ed.push_back(8'hF4); ed.push_back(8'h01); ed.push_back(8'h07);
      el = {};
      for (int i = 0; i < 12; i++) el.push_back(i == 9 || i == 11);
      clear_queues(); a_m.ready = 1'b1;
      send_a(f, 0);
      f = {8'h01};
      send_a(f, 0);
      wait_beats(12, 0);
      n_vec++; if (qa_d.size() !== 12) begin n_err++; $display("FAIL check_count: got %0d want 12", qa_d.size()); end
      for (int i = 0; i < ed.size() && i < qa_d.size(); i++) begin
         n_vec++;
         if (qa_d[i] !== ed[i] || qa_l[i] !== el[i]) begin
            n_err++; $display("FAIL check_beat%0d: got %h/%b want %h/%b", i, qa_d[i], qa_l[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_crc16();
      bq_t f, eb, ec; logic el[$];
      f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      eb = f; eb.push_back(8'h31); eb.push_back(8'hC3);
      ec = f; ec.push_back(8'h29); ec.push_back(8'hB1);
      el = {};
      for (int i = 0; i < 11; i++) el.push_back(i == 10);
      clear_queues();
      send_bc(f); wait_beats(0, 11);
      n_vec++; if (qb_d.size() !== 11) begin n_err++; $display("FAIL crc16_b_count: got %0d want 11", qb_d.size()); end
      n_vec++; if (qc_d.size() !== 11) begin n_err++; $display("FAIL crc16_c_count: got %0d want 11", qc_d.size()); end
      for (int i = 0; i < 11 && i < qb_d.size(); i++) begin
         n_vec++;
         if (qb_d[i] !== eb[i] || qb_l[i] !== el[i]) begin
            n_err++; $display("FAIL crc16_init0_beat%0d: got %h/%b want %h/%b", i, qb_d[i], qb_l[i], eb[i], el[i]);
         end
      end
      for (int i = 0; i < 11 && i < qc_d.size(); i++) begin
         n_vec++;
         if (qc_d[i] !== ec[i] || qc_l[i] !== el[i]) begin
            n_err++; $display("FAIL crc16_initF_beat%0d: got %h/%b want %h/%b", i, qc_d[i], qc_l[i], ec[i], el[i]);
         end
      end
   endtask

   task automatic test_random_backpressure();
      bq_t   frames[$];
      bq_t   f;
      bq_t   ed;
      logic  el[$];
      logic [15:0] crc;
      int    len;
      for (int k = 0; k < 100; k++) begin
         f = {};
         len = int'($urandom_range(8, 1));
         for (int i = 0; i < len; i++) f.push_back(8'($urandom));
         frames.push_back(f);
         crc = ref_crc(f, 8, 16'h0007, 16'h0000, 16'h0000);
         foreach (f[i]) begin ed.push_back(f[i]); el.push_back(1'b0); end
         ed.push_back(crc[7:0]); el.push_back(1'b1);
      end
      nexp = ed.size(); drv_done = 1'b0;
      clear_queues();
      fork
         begin
            foreach (frames[k]) send_a(frames[k], 30);
            drv_done = 1'b1;
         end
         begin
            int t; logic stall; logic [7:0] pd; logic pl;
            t = 0; stall = 1'b0; pd = '0; pl = 1'b0;
            while ((!drv_done || qa_d.size() < nexp) && t < 30000) begin
               @(negedge clk); t++;
               if (stall) begin
                  n_vec++;
                  if (a_m.valid !== 1'b1 || a_m.data !== pd || a_m.last !== pl) begin
                     n_err++; $display("FAIL hold_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                       a_m.valid, a_m.data, a_m.last, pd, pl);
                  end
               end
               stall = a_m.valid && !a_m.ready; pd = a_m.data; pl = a_m.last;
               @(posedge clk); #1;
               a_m.ready = 1'($urandom_range(1));
            end
            a_m.ready = 1'b1;
         end
      join
      wait_beats(nexp, 0);
      n_vec++; if (qa_d.size() !== nexp) begin n_err++; $display("FAIL random_count: got %0d want %0d", qa_d.size(), nexp); end
      for (int i = 0; i < nexp && i < qa_d.size(); i++) begin
         n_vec++;
         if (qa_d[i] !== ed[i] || qa_l[i] !== el[i]) begin
            n_err++; $display("FAIL random_beat%0d: got %h/%b want %h/%b", i, qa_d[i], qa_l[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bq_t f1, f2, ed; logic el[$]; logic [15:0] crc;
      f1 = {8'($urandom), 8'($urandom), 8'($urandom)};
      f2 = {8'($urandom), 8'($urandom)};
      ed = {}; el = {};
      foreach (f1[i]) begin ed.push_back(f1[i]); el.push_back(1'b0); end
      crc = ref_crc(f1, 8, 16'h0007, 16'h0000, 16'h0000); ed.push_back(crc[7:0]); el.push_back(1'b1);
      foreach (f2[i]) begin ed.push_back(f2[i]); el.push_back(1'b0); end
      crc = ref_crc(f2, 8, 16'h0007, 16'h0000, 16'h0000); ed.push_back(crc[7:0]); el.push_back(1'b1);
      clear_queues(); a_m.ready = 1'b1; stall_cnt = 0;
      send_a(f1, 0);
      send_a(f2, 0);
      wait_beats(7, 0);
      n_vec++; if (stall_cnt !== 1) begin n_err++; $display("FAIL b2b_stall_cycles: got %0d want 1", stall_cnt); end
      n_vec++; if (qa_d.size() !== 7) begin n_err++; $display("FAIL b2b_count: got %0d want 7", qa_d.size()); end
      for (int i = 0; i < 7 && i < qa_d.size(); i++) begin
         n_vec++;
         if (qa_d[i] !== ed[i] || qa_l[i] !== el[i]) begin
            n_err++; $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, qa_d[i], qa_l[i], ed[i], el[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bq_t f, ed; logic el[$]; int t;
      a_m.ready = 1'b1;
      a_s.valid = 1'b1; a_s.data = 8'hA5; a_s.last = 1'b0;
      @(posedge clk); #1; @(posedge clk); #1;
      rst = 1'b1; #1;
      n_vec++; if (a_m.valid !== 1'b0 || a_m.data !== 8'h00 || a_m.last !== 1'b0 || a_busy !== 1'b0)
         begin n_err++; $display("FAIL rst_data_outputs: got v=%b d=%h l=%b busy=%b want all 0", a_m.valid, a_m.data, a_m.last, a_busy); end
      n_vec++; if (a_s.ready !== 1'b0) begin n_err++; $display("FAIL rst_data_s_ready: got %b want 0", a_s.ready); end
      a_s.valid = 1'b0;
      @(posedge clk); #1; rst = 1'b0;
      b_s.valid = 1'b1; b_s.data = 8'h31; b_s.last = 1'b1;
      @(posedge clk); #1; b_s.valid = 1'b0; b_s.last = 1'b0;
      t = 0;
      while (!(b_m.valid && b_m.last) && t < 50) begin @(negedge clk); t++; end
      n_vec++; if (t >= 50) begin n_err++; $display("FAIL rst_crc_reach_beat2: got no m_last beat want one"); end
      #1; rst = 1'b1; #1;
      n_vec++; if (b_m.valid !== 1'b0 || b_m.data !== 8'h00 || b_m.last !== 1'b0 || b_busy !== 1'b0)
         begin n_err++; $display("FAIL rst_crc_outputs: got v=%b d=%h l=%b busy=%b want all 0", b_m.valid, b_m.data, b_m.last, b_busy); end
      @(posedge clk); #1; rst = 1'b0;
      clear_queues();
      f = {8'h01};
      send_a(f, 0);
      send_bc(f);
      wait_beats(2, 3);
      ed = {8'h01, 8'h07}; el = {1'b0, 1'b1};
      n_vec++; if (qa_d.size() !== 2) begin n_err++; $display("FAIL post_rst_count: got %0d want 2", qa_d.size()); end
      for (int i = 0; i < 2 && i < qa_d.size(); i++) begin
         n_vec++;
         if (qa_d[i] !== ed[i] || qa_l[i] !== el[i]) begin
            n_err++; $display("FAIL post_rst_beat%0d: got %h/%b want %h/%b", i, qa_d[i], qa_l[i], ed[i], el[i]);
         end
      end
      ed = {8'h01, 8'h10, 8'h21}; el = {1'b0, 1'b0, 1'b1};
      n_vec++; if (qb_d.size() !== 3) begin n_err++; $display("FAIL post_rst_b_count: got %0d want 3", qb_d.size()); end
      for (int i = 0; i < 3 && i < qb_d.size(); i++) begin
         n_vec++;
         if (qb_d[i] !== ed[i] || qb_l[i] !== el[i]) begin
            n_err++; $display("FAIL post_rst_b_beat%0d: got %h/%b want %h/%b", i, qb_d[i], qb_l[i], ed[i], el[i]);
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, time=%0t want under 900000", $time);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      a_s.valid = 1'b0; a_s.data = '0; a_s.last = 1'b0; a_m.ready = 1'b1;
      b_s.valid = 1'b0; b_s.data = '0; b_s.last = 1'b0; b_m.ready = 1'b1;
      c_s.valid = 1'b0; c_s.data = '0; c_s.last = 1'b0; c_m.ready = 1'b1;
      drv_done = 1'b0; nexp = 0;
      test_reset();
      test_single_word();
      test_check_string();
      test_crc16();
      test_random_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
